seg7_scan: RTL

//  Two-digit multiplexed seven-segment driver, downstream of the SoC core in the chip wrapper.

---
 rtl/seg7_scan.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment driver.
// Scans the two nibbles of a frame-latched display byte onto SEG_o/COM_o,
// with optional all-off dead time between digits and a frame tick when a
// new display value is loaded.
module seg7_scan #(
    parameter int SCAN_DIV       = 62500,
    parameter int DEAD           = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic [1:0] wr_dp,
    input  logic       blank,
    output logic [7:0] SEG_o,
    output logic [1:0] COM_o,
    output logic       frame_tick
);

    localparam int CNT_M1    = (SCAN_DIV > DEAD) ? SCAN_DIV : DEAD;
    localparam int CNT_RANGE = (CNT_M1 > 2) ? CNT_M1 : 2;
    localparam int CW        = $clog2(CNT_RANGE);

    localparam logic [CW-1:0] DIG_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD > 0) ? (DEAD - 1) : 0);

    // Pin levels that mean "nothing lit" for the chosen polarities.
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0] COM_OFF = COM_ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        DIG0  = 2'd0,
        DEAD0 = 2'd1,
        DIG1  = 2'd2,
        DEAD1 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]  pending_q, pending_d;   // {dp[1:0], data[7:0]}
    logic [9:0]  display_q, display_d;
    logic        tick_q, tick_d;
    logic [7:0]  seg_q, seg_d;
    logic [1:0]  com_q, com_d;
    logic        boundary;
    logic [7:0]  seg_raw;
    logic [1:0]  com_raw;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan FSM next state, phase counter, pending/display loads at the frame boundary.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        boundary  = 1'b0;
        pending_d = wr_en ? {wr_dp, wr_data} : pending_q;
        display_d = display_q;

        case (state_q)
            DIG0: begin
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD == 0) ? DIG1 : DEAD0;
                end
            end
            DEAD0: begin
                if ((DEAD == 0) || (cnt_q == DEAD_LAST)) begin
                    cnt_d   = '0;
                    state_d = DIG1;
                end
            end
            DIG1: begin
                if (cnt_q == DIG_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD == 0) ? DIG0 : DEAD1;
                    // Without dead time the frame boundary is DIG1 -> DIG0.
                    boundary = (DEAD == 0);
                end
            end
            default: begin
                if ((DEAD == 0) || (cnt_q == DEAD_LAST)) begin
                    cnt_d    = '0;
                    state_d  = DIG0;
                    boundary = 1'b1;
                end
            end
        endcase

        // A write landing on the boundary cycle goes straight to the display.
        if (boundary) begin
            display_d = wr_en ? {wr_dp, wr_data} : pending_q;
        end
        tick_d = boundary;
    end

    // Output pattern for the current state, then blanking, then pin polarity.
    always_comb begin
        seg_raw = 8'h00;
        com_raw = 2'b00;
        case (state_q)
            DIG0: begin
                com_raw = 2'b01;
                seg_raw = {display_q[8], decode(display_q[3:0])};
            end
            DIG1: begin
                com_raw = 2'b10;
                seg_raw = {display_q[9], decode(display_q[7:4])};
            end
            default: begin
                com_raw = 2'b00;
                seg_raw = 8'h00;
            end
        endcase
        if (blank) begin
            com_raw = 2'b00;
            seg_raw = 8'h00;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        com_d = COM_ACTIVE_LOW ? ~com_raw : com_raw;
    end

    // State, counter, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DEAD1;
            cnt_q     <= '0;
            pending_q <= '0;
            display_q <= '0;
            tick_q    <= 1'b0;
            seg_q     <= SEG_OFF;
            com_q     <= COM_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            display_q <= display_d;
            tick_q    <= tick_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
        end
    end

    assign SEG_o      = seg_q;
    assign COM_o      = com_q;
    assign frame_tick = tick_q;

endmodule
